// File: rtl/cu_pkg.sv
// cu_pkg: shared types and constants for the multicycle control unit.
//   state_t  : FSM state encoding (also exported on the debug port "state")
//   iclass_t : decoded instruction class produced by cu_decode
//   ctrl_t   : packed bundle of every single-bit control strobe/select
//   OP_*, FN_*, ALU_ADD, REL_* : instruction field encodings
package cu_pkg;

  typedef enum logic [2:0] {
    S_RST, S_IF, S_ID, S_EX, S_MEM, S_EX2, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LD, C_ST, C_BR, C_CALL, C_RET, C_HALT, C_ILL
  } iclass_t;

  localparam logic [2:0] OP_RALU    = 3'b000;
  localparam logic [2:0] OP_IALU    = 3'b001;
  localparam logic [2:0] OP_LDST    = 3'b010;
  localparam logic [2:0] OP_BR      = 3'b011;
  localparam logic [2:0] OP_CALLRET = 3'b100;
  localparam logic [2:0] OP_HALT    = 3'b111;

  localparam logic [4:0] FN_LD   = 5'd0;
  localparam logic [4:0] FN_ST   = 5'd1;
  localparam logic [4:0] FN_CALL = 5'd0;
  localparam logic [4:0] FN_RET  = 5'd1;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  localparam logic [1:0] REL_ZERO   = 2'b00;
  localparam logic [1:0] REL_GT     = 2'b01;
  localparam logic [1:0] REL_LT     = 2'b10;
  localparam logic [1:0] REL_ALWAYS = 2'b11;

  typedef struct packed {
    logic loadPC;
    logic loadNPC;
    logic readIM;
    logic loadIR;
    logic readRegPort1;
    logic readRegPort2;
    logic loadA;
    logic loadB;
    logic loadIMM;
    logic loadIMM1;
    logic muxALU1;
    logic muxALU2;
    logic loadALUout;
    logic muxPC;
    logic readDM;
    logic writeDM;
    logic loadLMD;
    logic muxWB;
    logic writeReg;
    logic muxIMM;
    logic muxDM;
    logic muxRET;
  } ctrl_t;

endpackage

// File: rtl/cu_decode.sv
// cu_decode: combinational instruction decoder.
//   IR       in  32  instruction register
//   iclass   out     instruction class (C_ILL for any undecoded opcode/funct)
//   illegal  out  1  high when iclass is C_ILL
//   imm_op   out  1  immediate-operand ALU instruction (selects IMM on ALU port 2)
//   alu_func out  4  ALU function field fn[4:1]
//   rel      out  2  branch condition field fn[1:0]
module cu_decode
  import cu_pkg::*;
(
  input  logic [31:0] IR,
  output iclass_t     iclass,
  output logic        illegal,
  output logic        imm_op,
  output logic [3:0]  alu_func,
  output logic [1:0]  rel
);

  logic [2:0] op;
  logic [4:0] fn;
  logic       unused_ir;

  assign op        = IR[31:29];
  assign fn        = IR[4:0];
  assign unused_ir = ^IR[28:5];

  always_comb begin
    iclass = C_ILL;
    case (op)
      OP_RALU, OP_IALU: iclass = C_ALU;
      OP_LDST: begin
        if (fn == FN_LD)      iclass = C_LD;
        else if (fn == FN_ST) iclass = C_ST;
      end
      OP_BR:   iclass = C_BR;
      OP_CALLRET: begin
        if (fn == FN_CALL)     iclass = C_CALL;
        else if (fn == FN_RET) iclass = C_RET;
      end
      OP_HALT: iclass = C_HALT;
      default: iclass = C_ILL;
    endcase
  end

  assign illegal  = (iclass == C_ILL);
  assign imm_op   = (op == OP_IALU);
  assign alu_func = fn[4:1];
  assign rel      = fn[1:0];

endmodule

// File: rtl/control_unit.sv
// control_unit: multicycle control FSM for the processor datapath.
//   clk, rst     : clock, synchronous active-high reset
//   IR           : instruction register from the datapath
//   mem_ready    : data-memory ready, present only when CU_MEM_WAIT_EN is defined
//   load*/read*/write*/mux* : datapath strobes and selects (registered)
//   ALUfunc      : ALU operation, muxREL : branch condition select
//   HALT         : high while halted, illegal : one-cycle pulse in EX on bad opcode
//   state        : current FSM state (debug)
// Configuration macro: CU_MEM_WAIT_EN adds mem_ready and lets S_MEM stretch.
// All outputs are registered: the output values for a state are computed from
// the next state (and the decoded IR) and loaded on the same edge as the state.
module control_unit
  import cu_pkg::*;
#(
  parameter int ALUF_W   = 4,
  parameter int RST_IDLE = 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       IR,
`ifdef CU_MEM_WAIT_EN
  input  logic              mem_ready,
`endif
  output logic              loadPC, loadNPC, readIM, loadIR,
  output logic              readRegPort1, readRegPort2, loadA, loadB, loadIMM, loadIMM1,
  output logic              muxALU1, muxALU2, loadALUout, muxPC, readDM, writeDM,
  output logic              loadLMD, muxWB, writeReg, muxIMM, muxDM, muxRET,
  output logic [ALUF_W-1:0] ALUfunc,
  output logic [1:0]        muxREL,
  output logic              HALT,
  output logic              illegal,
  output state_t            state
);

  iclass_t            iclass;
  logic               dec_illegal, imm_op, mem_go;
  logic [3:0]         dec_alu;
  logic [1:0]         dec_rel;
  logic [7:0]         idle_cnt;
  state_t             nxt_state;
  ctrl_t              ctrl_q, nxt_ctrl;
  logic [ALUF_W-1:0]  nxt_alu;
  logic [1:0]         nxt_rel;
  logic               nxt_halt, nxt_illegal;

`ifdef CU_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  assign mem_go = 1'b1;
`endif

  cu_decode u_decode (
    .IR       (IR),
    .iclass   (iclass),
    .illegal  (dec_illegal),
    .imm_op   (imm_op),
    .alu_func (dec_alu),
    .rel      (dec_rel)
  );

  always_comb begin
    nxt_state   = state;
    nxt_ctrl    = '0;
    nxt_alu     = '0;
    nxt_rel     = '0;
    nxt_halt    = 1'b0;
    nxt_illegal = 1'b0;

    case (state)
      S_RST:  if (idle_cnt >= 8'(RST_IDLE - 1)) nxt_state = S_IF;
      S_IF:   nxt_state = S_ID;
      S_ID:   nxt_state = (iclass == C_HALT) ? S_HALT : S_EX;
      S_EX:   nxt_state = (iclass == C_ALU || iclass == C_BR || iclass == C_ILL) ? S_WB : S_MEM;
      S_MEM:  if (mem_go) nxt_state = (iclass == C_CALL) ? S_EX2 : S_WB;
      S_EX2:  nxt_state = S_WB;
      S_WB:   nxt_state = S_IF;
      S_HALT: nxt_state = S_HALT;
      default: nxt_state = S_RST;
    endcase

    // Outputs belonging to the state being entered.
    case (nxt_state)
      S_IF: begin
        nxt_ctrl.readIM  = 1'b1;
        nxt_ctrl.loadIR  = 1'b1;
        nxt_ctrl.loadNPC = 1'b1;
      end
      S_ID: begin
        nxt_ctrl.readRegPort1 = 1'b1;
        nxt_ctrl.readRegPort2 = 1'b1;
        nxt_ctrl.loadA        = 1'b1;
        nxt_ctrl.loadB        = 1'b1;
        nxt_ctrl.loadIMM      = 1'b1;
        nxt_ctrl.loadIMM1     = 1'b1;
      end
      S_EX: begin
        nxt_ctrl.loadALUout = 1'b1;
        nxt_illegal         = dec_illegal;
        case (iclass)
          C_ALU: begin
            nxt_alu          = ALUF_W'(dec_alu);
            nxt_ctrl.muxALU2 = imm_op;
          end
          C_LD, C_ST, C_CALL, C_RET: begin
            nxt_alu          = ALUF_W'(ALU_ADD);
            nxt_ctrl.muxALU2 = 1'b1;
          end
          C_BR: begin
            nxt_alu          = ALUF_W'(ALU_ADD);
            nxt_ctrl.muxALU1 = 1'b1;
            nxt_ctrl.muxALU2 = 1'b1;
            nxt_ctrl.muxIMM  = (dec_rel == REL_ALWAYS);
          end
          default: ;
        endcase
      end
      S_MEM: begin
        case (iclass)
          C_LD, C_RET: begin
            nxt_ctrl.readDM  = 1'b1;
            nxt_ctrl.loadLMD = 1'b1;
          end
          C_ST: nxt_ctrl.writeDM = 1'b1;
          C_CALL: begin
            // Push the return address (NPC) onto the stack.
            nxt_ctrl.writeDM = 1'b1;
            nxt_ctrl.muxDM   = 1'b1;
          end
          default: ;
        endcase
      end
      S_EX2: begin
        // Second ALU pass for CALL computes the jump target.
        nxt_alu             = ALUF_W'(ALU_ADD);
        nxt_ctrl.muxALU1    = 1'b1;
        nxt_ctrl.muxALU2    = 1'b1;
        nxt_ctrl.muxIMM     = 1'b1;
        nxt_ctrl.loadALUout = 1'b1;
      end
      S_WB: begin
        nxt_ctrl.loadPC = 1'b1;
        case (iclass)
          C_ALU: begin
            nxt_ctrl.writeReg = 1'b1;
            nxt_ctrl.muxWB    = 1'b1;
          end
          C_LD: nxt_ctrl.writeReg = 1'b1;
          C_BR: begin
            nxt_ctrl.muxPC = 1'b1;
            nxt_rel        = dec_rel;
          end
          C_CALL: begin
            nxt_ctrl.muxPC = 1'b1;
            nxt_rel        = REL_ALWAYS;
          end
          C_RET: nxt_ctrl.muxRET = 1'b1;
          default: ;  // ST and illegal: PC <- NPC only
        endcase
      end
      S_HALT: nxt_halt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RST;
      idle_cnt <= '0;
      ctrl_q   <= '0;
      ALUfunc  <= '0;
      muxREL   <= '0;
      HALT     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state <= nxt_state;
      if (state == S_RST && nxt_state == S_RST) idle_cnt <= idle_cnt + 8'd1;
      ctrl_q  <= nxt_ctrl;
      ALUfunc <= nxt_alu;
      muxREL  <= nxt_rel;
      HALT    <= nxt_halt;
      illegal <= nxt_illegal;
    end
  end

  assign loadPC       = ctrl_q.loadPC;
  assign loadNPC      = ctrl_q.loadNPC;
  assign readIM       = ctrl_q.readIM;
  assign loadIR       = ctrl_q.loadIR;
  assign readRegPort1 = ctrl_q.readRegPort1;
  assign readRegPort2 = ctrl_q.readRegPort2;
  assign loadA        = ctrl_q.loadA;
  assign loadB        = ctrl_q.loadB;
  assign loadIMM      = ctrl_q.loadIMM;
  assign loadIMM1     = ctrl_q.loadIMM1;
  assign muxALU1      = ctrl_q.muxALU1;
  assign muxALU2      = ctrl_q.muxALU2;
  assign loadALUout   = ctrl_q.loadALUout;
  assign muxPC        = ctrl_q.muxPC;
  assign readDM       = ctrl_q.readDM;
  assign writeDM      = ctrl_q.writeDM;
  assign loadLMD      = ctrl_q.loadLMD;
  assign muxWB        = ctrl_q.muxWB;
  assign writeReg     = ctrl_q.writeReg;
  assign muxIMM       = ctrl_q.muxIMM;
  assign muxDM        = ctrl_q.muxDM;
  assign muxRET       = ctrl_q.muxRET;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed, cycle-by-cycle check of every control output of
// control_unit against hand-written expected vectors. Honours CU_MEM_WAIT_EN.
module tb_control_unit;
  import cu_pkg::*;

  logic        clk, rst, mem_ready;
  logic [31:0] IR;
  logic loadPC, loadNPC, readIM, loadIR, readRegPort1, readRegPort2, loadA, loadB;
  logic loadIMM, loadIMM1, muxALU1, muxALU2, loadALUout, muxPC, readDM, writeDM;
  logic loadLMD, muxWB, writeReg, muxIMM, muxDM, muxRET, HALT, illegal;
  logic [3:0]  ALUfunc;
  logic [1:0]  muxREL;
  state_t      state;
  logic [29:0] obs;

  int checks   = 0;
  int failures = 0;

  control_unit #(.ALUF_W(4), .RST_IDLE(1)) dut (
    .clk(clk), .rst(rst), .IR(IR),
`ifdef CU_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .loadPC(loadPC), .loadNPC(loadNPC), .readIM(readIM), .loadIR(loadIR),
    .readRegPort1(readRegPort1), .readRegPort2(readRegPort2), .loadA(loadA), .loadB(loadB),
    .loadIMM(loadIMM), .loadIMM1(loadIMM1), .muxALU1(muxALU1), .muxALU2(muxALU2),
    .loadALUout(loadALUout), .muxPC(muxPC), .readDM(readDM), .writeDM(writeDM),
    .loadLMD(loadLMD), .muxWB(muxWB), .writeReg(writeReg), .muxIMM(muxIMM),
    .muxDM(muxDM), .muxRET(muxRET), .ALUfunc(ALUfunc), .muxREL(muxREL),
    .HALT(HALT), .illegal(illegal), .state(state)
  );

  assign obs = {HALT, illegal, muxREL, ALUfunc, muxRET, muxDM, muxIMM, writeReg, muxWB,
                loadLMD, writeDM, readDM, muxPC, loadALUout, muxALU2, muxALU1, loadIMM1,
                loadIMM, loadB, loadA, readRegPort2, readRegPort1, loadIR, readIM, loadNPC, loadPC};

  localparam logic [29:0] B_LOADPC   = 30'd1 << 0;
  localparam logic [29:0] B_LOADNPC  = 30'd1 << 1;
  localparam logic [29:0] B_READIM   = 30'd1 << 2;
  localparam logic [29:0] B_LOADIR   = 30'd1 << 3;
  localparam logic [29:0] B_RP1      = 30'd1 << 4;
  localparam logic [29:0] B_RP2      = 30'd1 << 5;
  localparam logic [29:0] B_LOADA    = 30'd1 << 6;
  localparam logic [29:0] B_LOADB    = 30'd1 << 7;
  localparam logic [29:0] B_LOADIMM  = 30'd1 << 8;
  localparam logic [29:0] B_LOADIMM1 = 30'd1 << 9;
  localparam logic [29:0] B_MUXALU1  = 30'd1 << 10;
  localparam logic [29:0] B_MUXALU2  = 30'd1 << 11;
  localparam logic [29:0] B_LOADALU  = 30'd1 << 12;
  localparam logic [29:0] B_MUXPC    = 30'd1 << 13;
  localparam logic [29:0] B_READDM   = 30'd1 << 14;
  localparam logic [29:0] B_WRITEDM  = 30'd1 << 15;
  localparam logic [29:0] B_LOADLMD  = 30'd1 << 16;
  localparam logic [29:0] B_MUXWB    = 30'd1 << 17;
  localparam logic [29:0] B_WRITEREG = 30'd1 << 18;
  localparam logic [29:0] B_MUXIMM   = 30'd1 << 19;
  localparam logic [29:0] B_MUXDM    = 30'd1 << 20;
  localparam logic [29:0] B_MUXRET   = 30'd1 << 21;
  localparam logic [29:0] B_ILLEGAL  = 30'd1 << 28;
  localparam logic [29:0] B_HALT     = 30'd1 << 29;

  localparam logic [29:0] E_IF = B_READIM | B_LOADIR | B_LOADNPC;
  localparam logic [29:0] E_ID = B_RP1 | B_RP2 | B_LOADA | B_LOADB | B_LOADIMM | B_LOADIMM1;

  function automatic logic [29:0] alu(input logic [3:0] f);
    return 30'(f) << 22;
  endfunction

  function automatic logic [29:0] rel(input logic [1:0] r);
    return 30'(r) << 26;
  endfunction

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [29:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input state_t exp);
    checks++;
    assert (state === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, state, exp);
    end
  endtask

  task automatic step(input string tag, input logic [29:0] exp);
    tick();
    chk(tag, exp);
  endtask

  initial begin
    rst = 1'b1;
    IR = 32'h0;
    mem_ready = 1'b1;

    // Reset held three cycles, then one idle cycle before the first fetch.
    for (int i = 0; i < 3; i++) step("reset", 30'd0);
    chk_state("reset_state", S_RST);
    rst = 1'b0;
    chk("reset_release", 30'd0);
    step("first_if", E_IF);

    // R-ALU fn=2 -> ALUfunc 0001, register operand
    IR = 32'h0000_0002;
    step("ralu_id", E_ID);
    step("ralu_ex", B_LOADALU | alu(4'b0001));
    step("ralu_wb", B_LOADPC | B_WRITEREG | B_MUXWB);
    step("ralu_if", E_IF);

    // I-ALU fn=01010 -> ALUfunc 0101, immediate operand
    IR = 32'h2000_000A;
    step("ialu_id", E_ID);
    step("ialu_ex", B_LOADALU | B_MUXALU2 | alu(4'b0101));
    step("ialu_wb", B_LOADPC | B_WRITEREG | B_MUXWB);
    step("ialu_if", E_IF);

    // LD
    IR = 32'h4000_0000;
    step("ld_id", E_ID);
    step("ld_ex", B_LOADALU | B_MUXALU2);
    step("ld_mem", B_READDM | B_LOADLMD);
    step("ld_wb", B_LOADPC | B_WRITEREG);
    step("ld_if", E_IF);

    // ST
    IR = 32'h4000_0001;
    step("st_id", E_ID);
    step("st_ex", B_LOADALU | B_MUXALU2);
    step("st_mem", B_WRITEDM);
    step("st_wb", B_LOADPC);
    step("st_if", E_IF);

    // Branch always
    IR = 32'h6000_0003;
    step("bra_id", E_ID);
    step("bra_ex", B_LOADALU | B_MUXALU1 | B_MUXALU2 | B_MUXIMM);
    step("bra_wb", B_LOADPC | B_MUXPC | rel(2'b11));
    step("bra_if", E_IF);

    // Branch if >0: no muxIMM
    IR = 32'h6000_0001;
    step("bgt_id", E_ID);
    step("bgt_ex", B_LOADALU | B_MUXALU1 | B_MUXALU2);
    step("bgt_wb", B_LOADPC | B_MUXPC | rel(2'b01));
    step("bgt_if", E_IF);

    // CALL: 6 cycles
    IR = 32'h8000_0000;
    step("call_id", E_ID);
    step("call_ex", B_LOADALU | B_MUXALU2);
    step("call_mem", B_WRITEDM | B_MUXDM);
    step("call_ex2", B_LOADALU | B_MUXALU1 | B_MUXALU2 | B_MUXIMM);
    step("call_wb", B_LOADPC | B_MUXPC | rel(2'b11));
    step("call_if", E_IF);

    // RET: 5 cycles
    IR = 32'h8000_0001;
    step("ret_id", E_ID);
    step("ret_ex", B_LOADALU | B_MUXALU2);
    step("ret_mem", B_READDM | B_LOADLMD);
    step("ret_wb", B_LOADPC | B_MUXRET);
    step("ret_if", E_IF);

    // Undecoded opcode: NOP with illegal pulse in EX
    IR = 32'hA000_0000;
    step("ill_id", E_ID);
    step("ill_ex", B_LOADALU | B_ILLEGAL);
    step("ill_wb", B_LOADPC);
    step("ill_if", E_IF);

    // LD/ST opcode with bad funct is also illegal
    IR = 32'h4000_0002;
    step("illfn_id", E_ID);
    step("illfn_ex", B_LOADALU | B_ILLEGAL);
    step("illfn_wb", B_LOADPC);
    step("illfn_if", E_IF);

    // Reset mid-instruction: LD aborted after EX, no MEM/WB strobes
    IR = 32'h4000_0000;
    step("abort_id", E_ID);
    step("abort_ex", B_LOADALU | B_MUXALU2);
    rst = 1'b1;
    step("abort_rst", 30'd0);
    rst = 1'b0;
    chk("abort_release", 30'd0);
    step("abort_if", E_IF);

    // HALT: halted from the third cycle, stays there
    IR = 32'hE000_0000;
    step("halt_id", E_ID);
    for (int i = 0; i < 20; i++) step("halt_hold", B_HALT);
    chk_state("halt_state", S_HALT);
    rst = 1'b1;
    step("halt_rst", 30'd0);
    rst = 1'b0;
    step("halt_resume", E_IF);

`ifdef CU_MEM_WAIT_EN
    // LD with memory not ready for three MEM cycles: latency 8
    IR = 32'h4000_0000;
    step("ldw_id", E_ID);
    step("ldw_ex", B_LOADALU | B_MUXALU2);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) step("ldw_mem", B_READDM | B_LOADLMD);
    mem_ready = 1'b1;
    step("ldw_wb", B_LOADPC | B_WRITEREG);
    step("ldw_if", E_IF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
